// File: rtl/logic_gate_sweep_ctrl_pkg.sv
// Shared types and constants for the logic_gate sweep controller and its settle timer.
package logic_gate_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } sweepState_e;

    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;
    localparam int SETTLE_W    = 4;
    localparam int MISMATCH_W  = 4;

    // Y = ~B | C evaluated for {A,B,C} = 0..7
    localparam logic [NUM_VECTORS-1:0] LOGIC_GATE_TRUTH = 8'hBB;

    // Mismatch counter increment that holds at the vector count
    function automatic logic [MISMATCH_W-1:0] satInc(input logic [MISMATCH_W-1:0] cnt);
        logic [MISMATCH_W-1:0] result;
        if (cnt >= MISMATCH_W'(NUM_VECTORS)) begin
            result = MISMATCH_W'(NUM_VECTORS);
        end else begin
            result = cnt + 1'b1;
        end
        return result;
    endfunction

endpackage

// File: rtl/logic_gate_sweep_ctrl_if.sv
// Control/status bundle between a test harness master and the sweep controller.
interface logic_gate_sweep_ctrl_if;
    import logic_gate_pkg::*;

    logic                         start;
    logic                         abort;
    logic                         busy;
    logic                         done;
    logic                         pass;
    logic [MISMATCH_W-1:0]        mismatch_cnt;
    logic [NUM_VECTORS-1:0]       fail_mask;
    logic [NUM_VECTORS-1:0]       result_vec;

    modport master (
        output start,
        output abort,
        input  busy,
        input  done,
        input  pass,
        input  mismatch_cnt,
        input  fail_mask,
        input  result_vec
    );

    modport slave (
        input  start,
        input  abort,
        output busy,
        output done,
        output pass,
        output mismatch_cnt,
        output fail_mask,
        output result_vec
    );

endinterface

// File: rtl/logic_gate_sweep_ctrl_settle_timer.sv
// Loadable down-counter that measures the settle window after each driven vector.
module logic_gate_settle_timer
    import logic_gate_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                en,
    input  logic [SETTLE_W-1:0] loadValue,
    output logic                zero
);

    logic [SETTLE_W-1:0] countReg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            countReg <= '0;
        end else if (load) begin
            countReg <= loadValue;
        end else if (en && (countReg != '0)) begin
            countReg <= countReg - 1'b1;
        end
    end

    assign zero = (countReg == '0);

endmodule

// File: rtl/logic_gate_sweep_ctrl.sv
// Sweeps logic_gate through all eight input vectors, samples Y after a settle window
// and records per-vector results against the expected truth table.
module logic_gate_sweep_ctrl
    import logic_gate_pkg::*;
#(
    parameter int                     SETTLE_CYCLES = 2,
    parameter logic [NUM_VECTORS-1:0] EXP_TRUTH     = LOGIC_GATE_TRUTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    logic_gate_sweep_ctrl_if.slave  ctrl,
    input  logic                    y_in,
    output logic                    a_out,
    output logic                    b_out,
    output logic                    c_out
);

    // SETTLE is entered only when SETTLE_CYCLES > 0, so the load value never wraps
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD =
        (SETTLE_CYCLES > 0) ? SETTLE_W'(SETTLE_CYCLES - 1) : '0;

    sweepState_e            stateReg, stateNext;
    logic [IDX_W-1:0]       idxReg;
    logic [IDX_W-1:0]       vecNext;
    logic [2:0]             abcReg;
    logic [MISMATCH_W-1:0]  mismatchCntReg, mismatchCntNext;
    logic                   passReg;
    logic                   resultBitReg [NUM_VECTORS];
    logic                   failBitReg   [NUM_VECTORS];
    logic [NUM_VECTORS-1:0] resultVec;
    logic [NUM_VECTORS-1:0] failMask;

    logic timerLoad, timerEn, timerZero;
    logic clearResults, sampleEn, lastVec, enterDrive, clearAbc, mismatchNow;

    logic_gate_settle_timer uSettleTimer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (timerLoad),
        .en        (timerEn),
        .loadValue (SETTLE_LOAD),
        .zero      (timerZero)
    );

    assign lastVec = (idxReg == IDX_W'(NUM_VECTORS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // abort is honoured in every busy state and takes priority over sampling
    always_comb begin
        stateNext    = stateReg;
        timerLoad    = 1'b0;
        timerEn      = 1'b0;
        clearResults = 1'b0;
        sampleEn     = 1'b0;
        case (stateReg)
            IDLE: begin
                if (ctrl.start && !ctrl.abort) begin
                    stateNext    = DRIVE;
                    clearResults = 1'b1;
                end
            end
            DRIVE: begin
                if (ctrl.abort) begin
                    stateNext = IDLE;
                end else if (SETTLE_CYCLES == 0) begin
                    stateNext = SAMPLE;
                end else begin
                    stateNext = SETTLE;
                    timerLoad = 1'b1;
                end
            end
            SETTLE: begin
                if (ctrl.abort) begin
                    stateNext = IDLE;
                end else if (timerZero) begin
                    stateNext = SAMPLE;
                end else begin
                    timerEn = 1'b1;
                end
            end
            SAMPLE: begin
                if (ctrl.abort) begin
                    stateNext = IDLE;
                end else begin
                    sampleEn  = 1'b1;
                    stateNext = lastVec ? DONE : DRIVE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign enterDrive  = clearResults || (sampleEn && !lastVec);
    assign vecNext     = clearResults ? '0 : (idxReg + 1'b1);
    assign clearAbc    = (stateNext == IDLE) || (stateNext == DONE);
    assign mismatchNow = sampleEn && (y_in != EXP_TRUTH[idxReg]);

    always_comb begin
        mismatchCntNext = mismatchCntReg;
        if (clearResults) begin
            mismatchCntNext = '0;
        end else if (mismatchNow) begin
            mismatchCntNext = satInc(mismatchCntReg);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idxReg         <= '0;
            abcReg         <= '0;
            mismatchCntReg <= '0;
            passReg        <= 1'b0;
        end else begin
            mismatchCntReg <= mismatchCntNext;
            if (enterDrive) begin
                idxReg <= vecNext;
                abcReg <= vecNext;
            end else if (clearAbc) begin
                abcReg <= '0;
            end
            // pass is decided on the edge into DONE so it is valid alongside done
            if (clearResults) begin
                passReg <= 1'b0;
            end else if (sampleEn && lastVec) begin
                passReg <= (mismatchCntNext == '0);
            end
        end
    end

    for (genvar gi = 0; gi < NUM_VECTORS; gi++) begin : gVecResult
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                resultBitReg[gi] <= 1'b0;
                failBitReg[gi]   <= 1'b0;
            end else if (clearResults) begin
                resultBitReg[gi] <= 1'b0;
                failBitReg[gi]   <= 1'b0;
            end else if (sampleEn && (idxReg == IDX_W'(gi))) begin
                resultBitReg[gi] <= y_in;
                failBitReg[gi]   <= (y_in != EXP_TRUTH[gi]);
            end
        end
        assign resultVec[gi] = resultBitReg[gi];
        assign failMask[gi]  = failBitReg[gi];
    end

    assign a_out = abcReg[2];
    assign b_out = abcReg[1];
    assign c_out = abcReg[0];

    assign ctrl.busy         = (stateReg == DRIVE) || (stateReg == SETTLE) || (stateReg == SAMPLE);
    assign ctrl.done         = (stateReg == DONE);
    assign ctrl.pass         = passReg;
    assign ctrl.mismatch_cnt = mismatchCntReg;
    assign ctrl.fail_mask    = failMask;
    assign ctrl.result_vec   = resultVec;

endmodule

// File: tb/tb_logic_gate_sweep_ctrl.sv
// Directed bench for logic_gate_sweep_ctrl with SETTLE_CYCLES = 2 and SETTLE_CYCLES = 0 instances.
module tb_logic_gate_sweep_ctrl;
    import logic_gate_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int yMode = 0;   // 0 = real gate, 1 = stuck-at-1, 2 = stuck-at-0
    logic sel = 1'b0;

    logic aA, bA, cA, yA;
    logic aB, bB, cB, yB;

    logic_gate_sweep_ctrl_if ifA ();
    logic_gate_sweep_ctrl_if ifB ();

    always_comb begin
        yA = (yMode == 1) ? 1'b1 : (yMode == 2) ? 1'b0 : (~bA | cA);
        yB = (yMode == 1) ? 1'b1 : (yMode == 2) ? 1'b0 : (~bB | cB);
    end

    logic_gate_sweep_ctrl #(.SETTLE_CYCLES(2)) dutA (
        .clk(clk), .rst_n(rst_n), .ctrl(ifA.slave), .y_in(yA),
        .a_out(aA), .b_out(bA), .c_out(cA)
    );

    logic_gate_sweep_ctrl #(.SETTLE_CYCLES(0)) dutB (
        .clk(clk), .rst_n(rst_n), .ctrl(ifB.slave), .y_in(yB),
        .a_out(aB), .b_out(bB), .c_out(cB)
    );

    logic       obsDone, obsBusy, obsPass;
    logic [3:0] obsCnt;
    logic [7:0] obsRes, obsFail;
    logic [2:0] obsAbc;

    always_comb begin
        if (sel) begin
            obsDone = ifB.done; obsBusy = ifB.busy; obsPass = ifB.pass;
            obsCnt  = ifB.mismatch_cnt; obsRes = ifB.result_vec; obsFail = ifB.fail_mask;
            obsAbc  = {aB, bB, cB};
        end else begin
            obsDone = ifA.done; obsBusy = ifA.busy; obsPass = ifA.pass;
            obsCnt  = ifA.mismatch_cnt; obsRes = ifA.result_vec; obsFail = ifA.fail_mask;
            obsAbc  = {aA, bA, cA};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setCtrl(input logic s, input logic ab);
        if (sel) begin
            ifB.start = s; ifB.abort = ab;
        end else begin
            ifA.start = s; ifA.abort = ab;
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_busy"}, 32'(obsBusy), 32'd0);
        check({tag, "_done"}, 32'(obsDone), 32'd0);
        check({tag, "_pass"}, 32'(obsPass), 32'd0);
        check({tag, "_cnt"},  32'(obsCnt),  32'd0);
        check({tag, "_fail"}, 32'(obsFail), 32'd0);
        check({tag, "_res"},  32'(obsRes),  32'd0);
        check({tag, "_abc"},  32'(obsAbc),  32'd0);
    endtask

    // Starts a sweep in cycle 0; latency counts edges up to the one that raises done
    task automatic runSweep(input logic useB, input int expLat, input logic [7:0] expRes,
                            input logic [7:0] expFail, input logic [3:0] expCnt,
                            input logic expPass, input logic repulse, input string tag);
        int lat;
        sel = useB;
        @(negedge clk);
        setCtrl(1'b1, 1'b0);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        setCtrl(1'b0, 1'b0);
        check({tag, "_busy"}, 32'(obsBusy), 32'd1);
        while (!obsDone && lat < 200) begin
            if (repulse && (lat == 5 || lat == 20)) setCtrl(1'b1, 1'b0);
            else setCtrl(1'b0, 1'b0);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        setCtrl(1'b0, 1'b0);
        check({tag, "_lat"},  32'(lat),     32'(expLat));
        check({tag, "_done"}, 32'(obsDone), 32'd1);
        check({tag, "_res"},  32'(obsRes),  32'(expRes));
        check({tag, "_fail"}, 32'(obsFail), 32'(expFail));
        check({tag, "_cnt"},  32'(obsCnt),  32'(expCnt));
        check({tag, "_pass"}, 32'(obsPass), 32'(expPass));
        check({tag, "_abc"},  32'(obsAbc),  32'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(obsDone), 32'd0);
        check({tag, "_idle"},       32'(obsBusy), 32'd0);
        check({tag, "_pass_hold"},  32'(obsPass), 32'(expPass));
    endtask

    initial begin
        int sawDone;
        ifA.start = 1'b0; ifA.abort = 1'b0;
        ifB.start = 1'b0; ifB.abort = 1'b0;
        #1;
        sel = 1'b0;
        checkAllZero("rstA");
        sel = 1'b1;
        checkAllZero("rstB");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Real gate, stuck-at-1, stuck-at-0 on the SETTLE_CYCLES = 2 instance
        yMode = 0;
        runSweep(1'b0, 33, 8'hBB, 8'h00, 4'd0, 1'b1, 1'b0, "real");
        yMode = 1;
        runSweep(1'b0, 33, 8'hFF, 8'h44, 4'd2, 1'b0, 1'b0, "stuck1");
        yMode = 2;
        runSweep(1'b0, 33, 8'h00, 8'hBB, 4'd6, 1'b0, 1'b0, "stuck0");
        yMode = 0;

        // start and abort together in IDLE: abort wins, results untouched
        sel = 1'b0;
        @(negedge clk);
        setCtrl(1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        setCtrl(1'b0, 1'b0);
        check("startabort_busy", 32'(obsBusy), 32'd0);
        check("startabort_fail", 32'(obsFail), 32'hBB);
        check("startabort_cnt",  32'(obsCnt),  32'd6);

        // abort during SAMPLE of vector 3 (cycle 16)
        @(negedge clk);
        setCtrl(1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        setCtrl(1'b0, 1'b0);
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("abort_pre_busy", 32'(obsBusy), 32'd1);
        check("abort_pre_abc",  32'(obsAbc),  32'd3);
        setCtrl(1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        setCtrl(1'b0, 1'b0);
        check("abort_busy", 32'(obsBusy), 32'd0);
        check("abort_abc",  32'(obsAbc),  32'd0);
        check("abort_done", 32'(obsDone), 32'd0);
        check("abort_res",  32'(obsRes[2:0]), 32'd3);
        check("abort_pass", 32'(obsPass), 32'd0);
        sawDone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (obsDone) sawDone++;
        end
        check("abort_no_done", 32'(sawDone), 32'd0);
        runSweep(1'b0, 33, 8'hBB, 8'h00, 4'd0, 1'b1, 1'b0, "post_abort");

        // start re-pulsed mid-sweep is ignored
        runSweep(1'b0, 33, 8'hBB, 8'h00, 4'd0, 1'b1, 1'b1, "repulse");

        // asynchronous reset during SETTLE of vector 5 (cycle 22)
        sel = 1'b0;
        @(negedge clk);
        setCtrl(1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        setCtrl(1'b0, 1'b0);
        repeat (21) @(posedge clk);
        @(negedge clk);
        check("midrst_pre_abc", 32'(obsAbc), 32'd5);
        rst_n = 1'b0;
        #1;
        checkAllZero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        runSweep(1'b0, 33, 8'hBB, 8'h00, 4'd0, 1'b1, 1'b0, "post_rst");

        // SETTLE_CYCLES = 0 instance
        yMode = 0;
        runSweep(1'b1, 17, 8'hBB, 8'h00, 4'd0, 1'b1, 1'b0, "s0_real");
        yMode = 1;
        runSweep(1'b1, 17, 8'hFF, 8'h44, 4'd2, 1'b0, 1'b0, "s0_stuck1");
        yMode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_gate_sweep_ctrl.md
Name: logic_gate_sweep_ctrl

Overview:
- Sequencer and self-checker for the three-input `logic_gate` block. Y = ~B | C, pure combinational, up to 6 ns worst-case path.
- Drives A/B/C through all 8 input vectors in ascending order {A,B,C} = 0..7.
- After each vector it waits a programmable settle time, samples Y, and compares it against the expected truth table.
- Sits beside `logic_gate` in the board-level test harness. Reports a pass/fail summary plus per-vector results.

Parameters:
- SETTLE_CYCLES, 2, clock cycles to wait after driving a vector before sampling Y. Range 0..15.
- EXP_TRUTH, 8'hBB, expected Y per vector; bit i = expected Y for {A,B,C} = i.

Ports:
- clk  input  1  system clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a sweep; honoured only in IDLE.
- abort  input  1  cancels a sweep in progress.
- y_in  input  1  Y output of `logic_gate`.
- a_out  output  1  drives gate input A (registered).
- b_out  output  1  drives gate input B (registered).
- c_out  output  1  drives gate input C (registered).
- busy  output  1  high in any state other than IDLE and DONE.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  1 when the last completed sweep had zero mismatches.
- mismatch_cnt  output  4  mismatch count of the last sweep, 0..8.
- fail_mask  output  8  bit i set if vector i mismatched.
- result_vec  output  8  bit i = sampled Y for vector i.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - State goes to IDLE; vector index = 0.
  - a/b/c_out = 0, busy = 0, done = 0, pass = 0.
  - mismatch_cnt = 0, fail_mask = 0, result_vec = 0.
- States: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start = 1 and abort = 0 goes to DRIVE.
  - On that edge: index = 0, mismatch_cnt = 0, fail_mask = 0, result_vec = 0, pass = 0.
- DRIVE (1 cycle):
  - {a_out,b_out,c_out} are loaded with index on entry and held until the next DRIVE.
  - Goes to SETTLE, or to SAMPLE if SETTLE_CYCLES = 0.
- SETTLE:
  - A down-counter loads SETTLE_CYCLES-1 on entry.
  - Goes to SAMPLE when the counter reaches 0, i.e. exactly SETTLE_CYCLES cycles in SETTLE.
- SAMPLE (1 cycle):
  - result_vec[index] <= y_in.
  - If y_in != EXP_TRUTH[index]: fail_mask[index] <= 1 and mismatch_cnt increments. The count saturates at 8, which is reachable but never exceeded.
  - If index = 7, go to DONE; otherwise index increments and the state goes to DRIVE.
- DONE (1 cycle):
  - done = 1; pass = (mismatch_cnt == 0), registered.
  - a/b/c_out return to 0. Then back to IDLE.
- Results hold until the next accepted start or reset.
- Latency: a start accepted at edge T produces done high in cycle T + 1 + 8*(SETTLE_CYCLES+2). With the default that is T+33.
- abort:
  - In any busy state, goes to IDLE on the next edge; a/b/c_out = 0.
  - No done pulse; pass stays 0.
  - Partial result_vec, fail_mask and mismatch_cnt remain visible.
  - In IDLE, abort together with start means abort wins and the sweep is not started.
  - In DONE, abort is ignored.
- start while busy or in DONE is ignored, with no restart and no effect on the run length.
- Timing constraint: clock period must exceed the gate's worst path (6 ns) plus y_in setup. The test harness uses 10 ns. y_in is same-domain, so no synchroniser is needed.
- Reset mid-operation forces all reset values immediately. No residual state may leak into the next sweep.

Decomposition:
- Shared package `logic_gate_pkg` holds:
  - the state enum;
  - NUM_VECTORS = 8;
  - LOGIC_GATE_TRUTH = 8'hBB, the default for EXP_TRUTH;
  - SETTLE_W = 4.
- One natural sub-module: `logic_gate_settle_timer`. It is a loadable down-counter with load, en, and zero outputs, instantiated once.
- Everything else stays inline.

Test Plan:
- Real `logic_gate` attached, SETTLE_CYCLES = 2, 10 ns clock, start pulse -> done at T+33, result_vec = 0xBB, fail_mask = 0x00, mismatch_cnt = 0, pass = 1.
- y_in tied to 1 (stuck-at-1 model) -> result_vec = 0xFF, fail_mask = 0x44, mismatch_cnt = 2, pass = 0.
- y_in tied to 0 -> result_vec = 0x00, fail_mask = 0xBB, mismatch_cnt = 6, pass = 0.
- abort during SAMPLE of vector 3 -> next cycle busy = 0, abc = 000, no done pulse, result_vec[2:0] = 3'b011. A following start runs a clean 33-cycle sweep ending with pass = 1.
- start re-pulsed at cycles T+5 and T+20, then rst_n low during SETTLE of vector 5 -> re-starts ignored (done still at T+33 in a run without reset). Reset drives all outputs to 0 asynchronously, and the next sweep is correct.
- SETTLE_CYCLES = 0 -> done at T+17, result_vec = 0xBB, pass = 1.
